// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM word packer.
//   state_e          : capture state machine encoding (IDLE, RUN, DRAIN)
//   *_DEF constants  : default parameter values for pdm_word_packer
package pdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int WORD_BITS_DEF    = 32;
  localparam int PACKET_WORDS_DEF = 64;
  localparam int CLK_DIV_DEF      = 25;

endpackage

// File: rtl/pdm_out_fifo.sv
// Two-entry output FIFO holding {tlast, tdata} words for the AXI-Stream side.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and entry; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop_i         : remove the head entry (ignored when empty)
//   data_o        : head entry, held stable until popped
//   full_o/empty_o: occupancy flags
module pdm_out_fifo #(
  parameter int DATA_W = 33
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);
  assign pop_ok_s  = pop_i && !empty_o;
  // When full, a concurrent pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the write lands there safely.
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign data_o    = mem_q[rd_ptr_q];

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = !wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = !rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= {DATA_W{1'b0}};
      mem_q[1] <= {DATA_W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pdm_word_packer.sv
// PDM capture front end: drives the microphone clock, samples the 1-bit PDM
// stream, packs it MSB-first into words and emits them as AXI-Stream packets
// of PACKET_WORDS words (tlast on the final word of each packet).
// Ports:
//   clk_i, rst_ni      : system clock, asynchronous active-low reset
//   enable_i           : run request (level)
//   pdm_clk_o          : microphone clock, 2*CLK_DIV clk_i cycles per period
//   pdm_data_i         : asynchronous PDM data
//   m_axis_*           : AXI-Stream master (tdata, tvalid, tlast, tready)
//   overflow_o         : sticky, a completed word was dropped (FIFO full)
//   busy_o             : state machine is not IDLE
//   test_mode_i        : only with PDM_TEST_PATTERN_EN defined; words carry
//                        a push counter instead of PDM data
module pdm_word_packer
  import pdm_pkg::*;
#(
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int WORD_BITS    = WORD_BITS_DEF,
  parameter int PACKET_WORDS = PACKET_WORDS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
`ifdef PDM_TEST_PATTERN_EN
  input  logic                 test_mode_i,
`endif
  output logic                 pdm_clk_o,
  input  logic                 pdm_data_i,
  output logic [WORD_BITS-1:0] m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  output logic                 m_axis_tlast_o,
  input  logic                 m_axis_tready_i,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_BITS);
  localparam int PKT_W = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PACKET_WORDS - 1);

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 pdm_clk_q, pdm_clk_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-2:0] shreg_q, shreg_d;
  logic [PKT_W-1:0]     word_cnt_q, word_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
`ifdef PDM_TEST_PATTERN_EN
  logic [WORD_BITS-1:0] pat_cnt_q, pat_cnt_d;
`endif

  logic                 running_s, wrap_s, strobe_s, word_done_s, last_s;
  logic                 pop_s, push_ok_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [WORD_BITS-1:0] word_s, push_data_s;

  assign running_s   = (state_q != IDLE);
  assign wrap_s      = running_s && (div_cnt_q == DIV_LAST);
  // Sampling happens on the wrap that takes the PDM clock from 1 to 0.
  assign strobe_s    = wrap_s && pdm_clk_q;
  assign word_s      = {shreg_q, sync_q[1]};
  assign word_done_s = strobe_s && (bit_cnt_q == BIT_LAST);
  assign last_s      = (word_cnt_q == PKT_LAST);
  assign pop_s       = !fifo_empty_s && m_axis_tready_i;
  assign push_ok_s   = word_done_s && (!fifo_full_s || pop_s);

  // Select the payload of a completed word; drained words are zero padding.
  always_comb begin
    push_data_s = word_s;
`ifdef PDM_TEST_PATTERN_EN
    if (test_mode_i) begin
      push_data_s = pat_cnt_q;
    end else begin
      push_data_s = word_s;
    end
`endif
    if (state_q == DRAIN) begin
      push_data_s = {WORD_BITS{1'b0}};
    end else begin
      push_data_s = push_data_s;
    end
  end

  // Divider, shifter, packet bookkeeping and state machine next-state logic.
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], pdm_data_i};
    div_cnt_d  = div_cnt_q;
    pdm_clk_d  = pdm_clk_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q;
`ifdef PDM_TEST_PATTERN_EN
    pat_cnt_d  = pat_cnt_q;
`endif

    if (wrap_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      pdm_clk_d = !pdm_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (strobe_s) begin
      shreg_d   = word_s[WORD_BITS-2:0];
      bit_cnt_d = word_done_s ? {BIT_W{1'b0}} : (bit_cnt_q + BIT_W'(1));
    end else begin
      shreg_d   = shreg_q;
    end

    // A dropped word leaves word_cnt alone so packet framing is preserved.
    if (push_ok_s) begin
      word_cnt_d = last_s ? {PKT_W{1'b0}} : (word_cnt_q + PKT_W'(1));
`ifdef PDM_TEST_PATTERN_EN
      pat_cnt_d  = pat_cnt_q + WORD_BITS'(1);
`endif
    end else if (word_done_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = RUN;
          bit_cnt_d  = {BIT_W{1'b0}};
          word_cnt_d = {PKT_W{1'b0}};
          overflow_d = 1'b0;
`ifdef PDM_TEST_PATTERN_EN
          pat_cnt_d  = {WORD_BITS{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!enable_i) begin
          if ((word_cnt_q == {PKT_W{1'b0}}) && (bit_cnt_q == {BIT_W{1'b0}})) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // The second exit covers a packet that completed on the very edge
        // RUN handed over, so no all-padding packet is generated.
        if (push_ok_s && last_s) begin
          state_d = IDLE;
        end else if ((word_cnt_q == {PKT_W{1'b0}}) && (bit_cnt_q == {BIT_W{1'b0}})) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Divider is parked (and PDM clock low) whenever the next state is IDLE.
    if (state_d == IDLE) begin
      div_cnt_d = {DIV_W{1'b0}};
      pdm_clk_d = 1'b0;
    end else if (state_q == IDLE) begin
      div_cnt_d = {DIV_W{1'b0}};
      pdm_clk_d = 1'b0;
    end else begin
      pdm_clk_d = pdm_clk_d;
    end
    busy_d = (state_d != IDLE);
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sync_q     <= 2'b00;
      div_cnt_q  <= {DIV_W{1'b0}};
      pdm_clk_q  <= 1'b0;
      bit_cnt_q  <= {BIT_W{1'b0}};
      shreg_q    <= {(WORD_BITS-1){1'b0}};
      word_cnt_q <= {PKT_W{1'b0}};
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PDM_TEST_PATTERN_EN
      pat_cnt_q  <= {WORD_BITS{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      div_cnt_q  <= div_cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      word_cnt_q <= word_cnt_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
`ifdef PDM_TEST_PATTERN_EN
      pat_cnt_q  <= pat_cnt_d;
`endif
    end
  end

  pdm_out_fifo #(
    .DATA_W (WORD_BITS + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (word_done_s),
    .data_i  ({last_s, push_data_s}),
    .pop_i   (pop_s),
    .data_o  ({m_axis_tlast_o, m_axis_tdata_o}),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign m_axis_tvalid_o = !fifo_empty_s;
  assign pdm_clk_o       = pdm_clk_q;
  assign overflow_o      = overflow_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_pdm_word_packer.sv
// Self-checking bench for pdm_word_packer. A microphone model presents the
// next bit of a source array after every falling PDM clock edge; the expected
// words are packed from that array MSB-first and compared with what the
// AXI-Stream side delivers.
module tb_pdm_word_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni, enable_i, pdm_data_i, m_axis_tready_i;
  logic        pdm_clk_o, m_axis_tvalid_o, m_axis_tlast_o, overflow_o, busy_o;
  logic [31:0] m_axis_tdata_o;
  logic        enable3, pdm_clk3, tvalid3, tlast3, overflow3, busy3;
  logic [31:0] tdata3;
`ifdef PDM_TEST_PATTERN_EN
  logic        test_mode_i;
`endif

  always #5 clk_i = ~clk_i;

  pdm_word_packer #(.CLK_DIV(2), .WORD_BITS(32), .PACKET_WORDS(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
`ifdef PDM_TEST_PATTERN_EN
    .test_mode_i(test_mode_i),
`endif
    .pdm_clk_o(pdm_clk_o), .pdm_data_i(pdm_data_i),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tready_i(m_axis_tready_i),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  pdm_word_packer #(.CLK_DIV(3), .WORD_BITS(32), .PACKET_WORDS(1)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable3),
`ifdef PDM_TEST_PATTERN_EN
    .test_mode_i(1'b0),
`endif
    .pdm_clk_o(pdm_clk3), .pdm_data_i(pdm_data_i),
    .m_axis_tdata_o(tdata3), .m_axis_tvalid_o(tvalid3),
    .m_axis_tlast_o(tlast3), .m_axis_tready_i(1'b1),
    .overflow_o(overflow3), .busy_o(busy3)
  );

  int          errors = 0;
  int          checks = 0;
  logic        src [0:1023];
  int          falls;
  logic        prev_pdm;
  logic [32:0] rx [$];
  logic [32:0] rx3 [$];
  logic [32:0] exp_q [$];
  int          budget, n_hi, n_lo;
  logic        saw_high, v_before;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes that complete at this edge, then model the mic.
  task automatic step();
    if (m_axis_tvalid_o && m_axis_tready_i) rx.push_back({m_axis_tlast_o, m_axis_tdata_o});
    if (tvalid3) rx3.push_back({tlast3, tdata3});
    @(posedge clk_i);
    #1;
    if (prev_pdm && !pdm_clk_o) begin
      falls++;
      pdm_data_i = src[falls];
    end
    prev_pdm = pdm_clk_o;
  endtask

  task automatic start_stream();
    falls      = 0;
    prev_pdm   = pdm_clk_o;
    pdm_data_i = src[0];
    rx.delete();
    exp_q.delete();
  endtask

  task automatic run_until_falls(input int n);
    budget = 0;
    while (falls < n && budget < 4000) begin
      step();
      budget++;
    end
    check($sformatf("reach_fall_%0d", n), 64'(falls >= n), 64'd1);
  endtask

  function automatic logic [31:0] pack(input int base);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 32; i++) w = {w[30:0], src[base + i]};
    return w;
  endfunction

  task automatic fill_pattern(input logic [31:0] p);
    for (int i = 0; i < 1024; i++) src[i] = p[31 - (i % 32)];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) src[i] = 1'($urandom & 32'd1);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, 64'(rx.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 64'(rx[i]), 64'(exp_q[i]));
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b0; enable3 = 1'b0; pdm_data_i = 1'b0;
    m_axis_tready_i = 1'b1; prev_pdm = 1'b0; falls = 0;
`ifdef PDM_TEST_PATTERN_EN
    test_mode_i = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast_o), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata_o), 64'd0);
    check("rst_pdm_clk", 64'(pdm_clk_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_ni = 1'b1;
    step(); step();

    // Steady capture of the 0xA5A5A5A5 pattern, including first-word latency.
    fill_pattern(32'hA5A5A5A5);
    start_stream();
    enable_i = 1'b1;
    budget = 0; v_before = 1'b0;
    while (falls < 32 && budget < 2000) begin
      v_before = m_axis_tvalid_o;
      step();
      budget++;
    end
    check("lat_reached", 64'(falls == 32), 64'd1);
    check("lat_tvalid_before", 64'(v_before), 64'd0);
    check("lat_tvalid_after", 64'(m_axis_tvalid_o), 64'd1);
    run_until_falls(128);
    enable_i = 1'b0;
    repeat (3) step();
    check("steady_busy_idle", 64'(busy_o), 64'd0);
    check("steady_pdm_idle", 64'(pdm_clk_o), 64'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'(i == 3), 32'hA5A5A5A5});
    check_rx("steady");

    // Steady capture of random data.
    fill_random();
    start_stream();
    enable_i = 1'b1;
    run_until_falls(128);
    enable_i = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'(i == 3), pack(32 * i)});
    check_rx("random");

    // PDM clock shape on the CLK_DIV=3 instance.
    rx3.delete();
    saw_high = 1'b0;
    repeat (10) begin step(); if (pdm_clk3) saw_high = 1'b1; end
    check("pdm3_idle_before", 64'(saw_high), 64'd0);
    enable3 = 1'b1;
    budget = 0;
    while (!pdm_clk3 && budget < 50) begin step(); budget++; end
    check("pdm3_first_rise", 64'(pdm_clk3), 64'd1);
    for (int p = 0; p < 2; p++) begin
      n_hi = 0; budget = 0;
      while (pdm_clk3 && budget < 50) begin n_hi++; step(); budget++; end
      n_lo = 0; budget = 0;
      while (!pdm_clk3 && budget < 50) begin n_lo++; step(); budget++; end
      check($sformatf("pdm3_high_%0d", p), 64'(n_hi), 64'd3);
      check($sformatf("pdm3_low_%0d", p), 64'(n_lo), 64'd3);
    end
    enable3 = 1'b0;
    budget = 0;
    while (busy3 && budget < 400) begin step(); budget++; end
    check("pdm3_back_idle", 64'(busy3), 64'd0);
    saw_high = 1'b0;
    repeat (10) begin step(); if (pdm_clk3) saw_high = 1'b1; end
    check("pdm3_idle_after", 64'(saw_high), 64'd0);
    check("pdm3_drain_count", 64'(rx3.size()), 64'd1);
    if (rx3.size() > 0) check("pdm3_drain_word", 64'(rx3[0]), {31'd0, 1'b1, 32'd0});
    check("pdm3_overflow", 64'(overflow3), 64'd0);

    // Backpressure: two words fit, the third is dropped, framing survives.
    fill_random();
    start_stream();
    m_axis_tready_i = 1'b0;
    enable_i = 1'b1;
    run_until_falls(64);
    check("bp_no_ovf_yet", 64'(overflow_o), 64'd0);
    check("bp_hold_data", 64'(m_axis_tdata_o), 64'(pack(0)));
    run_until_falls(96);
    check("bp_overflow", 64'(overflow_o), 64'd1);
    check("bp_still_held", 64'(m_axis_tdata_o), 64'(pack(0)));
    check("bp_tvalid", 64'(m_axis_tvalid_o), 64'd1);
    m_axis_tready_i = 1'b1;
    run_until_falls(160);
    enable_i = 1'b0;
    repeat (3) step();
    check("bp_ovf_sticky", 64'(overflow_o), 64'd1);
    exp_q.push_back({1'b0, pack(0)});
    exp_q.push_back({1'b0, pack(32)});
    exp_q.push_back({1'b0, pack(96)});
    exp_q.push_back({1'b1, pack(128)});
    check_rx("bp");

    // Drain after 1 word + 5 bits; a brief re-enable during DRAIN is ignored.
    fill_random();
    start_stream();
    enable_i = 1'b1;
    step();
    check("drain_ovf_cleared", 64'(overflow_o), 64'd0);
    run_until_falls(37);
    enable_i = 1'b0;
    run_until_falls(80);
    enable_i = 1'b1;
    check("drain_busy", 64'(busy_o), 64'd1);
    run_until_falls(90);
    enable_i = 1'b0;
    run_until_falls(128);
    check("drain_idle_busy", 64'(busy_o), 64'd0);
    repeat (3) step();
    exp_q.push_back({1'b0, pack(0)});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b1, 32'd0});
    check_rx("drain");

`ifdef PDM_TEST_PATTERN_EN
    // Test pattern: words carry the push count.
    test_mode_i = 1'b1;
    start_stream();
    enable_i = 1'b1;
    run_until_falls(128);
    enable_i = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'(i == 3), 32'(i)});
    check_rx("pattern");
    test_mode_i = 1'b0;
`endif

    // Asynchronous reset mid-word with a held word and overflow pending.
    fill_random();
    start_stream();
    m_axis_tready_i = 1'b0;
    enable_i = 1'b1;
    run_until_falls(97);
    budget = 0;
    while (!pdm_clk_o && budget < 20) begin step(); budget++; end
    check("pre_rst_tvalid", 64'(m_axis_tvalid_o), 64'd1);
    check("pre_rst_ovf", 64'(overflow_o), 64'd1);
    check("pre_rst_pdm", 64'(pdm_clk_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    check("arst_tlast", 64'(m_axis_tlast_o), 64'd0);
    check("arst_pdm", 64'(pdm_clk_o), 64'd0);
    check("arst_ovf", 64'(overflow_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    enable_i = 1'b0;
    m_axis_tready_i = 1'b1;
    #2;
    rst_ni = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_word_packer.md
Name: pdm_word_packer

Overview:
- Upstream feeder of the Ethernet packet generator.
- Drives the PDM microphone clock, samples the 1-bit PDM stream and packs bits MSB-first into 32-bit words.
- Emits the words as an AXI-Stream master, asserting tlast on every PACKET_WORDS-th word, so each burst maps to exactly one Ethernet payload.
- Includes a 2-entry output FIFO and sticky overflow reporting.

Parameters:
- CLK_DIV, 25, clk_i cycles per PDM clock half-period (≥2); 50 MHz clk_i gives a 1 MHz PDM clock.
- WORD_BITS, 32, bits per output word.
- PACKET_WORDS, 64, words per packet; tlast is asserted on the last one (≥1).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  run request; level-sensitive
- pdm_clk_o  out  1  PDM microphone clock
- pdm_data_i  in  1  PDM data, asynchronous to clk_i
- m_axis_tdata_o  out  WORD_BITS  packed word
- m_axis_tvalid_o  out  1  word valid
- m_axis_tlast_o  out  1  last word of packet
- m_axis_tready_i  in  1  downstream ready
- overflow_o  out  1  sticky: a word was dropped
- busy_o  out  1  high when state is not IDLE

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; divider, bit counter and word counter 0.
- Synchronizer: pdm_data_i passes through a 2-flop synchronizer. Its output is the only sampled value.
- Divider:
  - Counts 0..CLK_DIV-1 while in RUN or DRAIN.
  - pdm_clk_o toggles on wrap.
  - Sample strobe fires in the cycle pdm_clk_o toggles 1->0.
  - pdm_clk_o is held 0 in IDLE.
- Shift: on each strobe, shreg <= {shreg[WORD_BITS-2:0], sync_bit}. After WORD_BITS strobes the word is complete. Bit counter wraps to 0.
- Word push:
  - A completed word is pushed with tlast = (word_cnt == PACKET_WORDS-1).
  - word_cnt increments only on a successful push and wraps to 0 after tlast.
  - If the FIFO is full at push time, the word is discarded, overflow_o is set and word_cnt is unchanged. Framing is preserved: every packet still has exactly PACKET_WORDS words.
- FIFO (2 entries):
  - Simultaneous push and pop when full is legal and is not an overflow.
  - m_axis_tvalid_o = !empty.
  - tdata/tlast come from the head entry and are held stable while tvalid=1 && tready=0.
  - Pop occurs on tvalid && tready.
- Latency: a word is visible on m_axis one cycle after its final sample strobe, if the FIFO was empty.
- State machine:
  - IDLE -> RUN when enable_i=1. Divider and bit counter are cleared on entry.
  - RUN -> IDLE when enable_i=0 and word_cnt=0 and bit_cnt=0.
  - RUN -> DRAIN when enable_i=0 and the packet is partial.
  - DRAIN: capture continues. Completed words are pushed as 0 (data zero-padded) until the tlast word is pushed, then -> IDLE.
  - enable_i re-asserted during DRAIN is ignored until IDLE is reached.
- overflow_o clears only on IDLE->RUN or reset.
- Reset mid-operation: immediate async clear. The FIFO contents are lost and the downstream sees tvalid drop; this is acceptable.

Optional Feature:
- Macro: PDM_TEST_PATTERN_EN.
- Defined: adds port test_mode_i (in, 1).
  - When 1, each pushed word is a 32-bit counter value instead of PDM data.
  - The counter starts at 0 on IDLE->RUN and increments per successful push.
  - Divider and strobe timing are unchanged; DRAIN padding still applies.
- Undefined: no port and no counter; data always comes from PDM.

Decomposition:
- Package pdm_pkg:
  - State enum (IDLE, RUN, DRAIN).
  - Constants WORD_BITS_DEF=32, PACKET_WORDS_DEF=64, CLK_DIV_DEF=25.
- Sub-module pdm_out_fifo: 2-entry FIFO of {tlast, tdata} with push/pop/full/empty.
- Divider, synchronizer and FSM stay in the top-level module.

Test Plan:
- Steady capture: CLK_DIV=2, PACKET_WORDS=4, pdm_data_i follows the pattern 0xA5A5A5A5 MSB-first, tready=1 -> four words of 0xA5A5A5A5, tlast only on the 4th, first tvalid 1 cycle after the 32nd falling edge.
- PDM clock: enable_i=1, CLK_DIV=3 -> pdm_clk_o period of 6 cycles, 50% duty; low and static in IDLE.
- Backpressure: tready=0 for 3 word times -> words 1-2 held in the FIFO, word 3 dropped, overflow_o=1, packet still 4 words with tlast on the 4th.
- Drain: deassert enable_i after 1 word plus 5 bits of a 4-word packet -> word 2 is 0x00000000 (padded), words 3-4 are 0, tlast on word 4, then IDLE with busy_o=0.
- Reset: assert rst_ni low mid-word -> tvalid, tlast, pdm_clk_o and overflow_o go to 0 in the same cycle, without a clock edge.
- With PDM_TEST_PATTERN_EN and test_mode_i=1 -> words 0,1,2,3 with tlast on word 3.
